// File: rtl/imem_loader_if.sv
// Byte-stream channel from the host byte source into the instruction-memory loader.
// Handshake: a byte moves on a rising clk edge where byte_valid and byte_ready are both high;
// the source holds byte_data stable while byte_valid is high and the byte has not been taken.
interface imem_loader_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: assembles little-endian words from a byte stream, writes them to instruction
// memory from address 0, verifies a trailing XOR checksum and releases the CPU reset on success.
module imem_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int WORDS  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W:0]     num_words,
  imem_loader_if.slave        bs,
  output logic                imem_we,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic [DATA_W-1:0]   imem_wdata,
  output logic                cpu_reset,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_CHK   = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam logic [ADDR_W:0]   NUM_MAX = (ADDR_W+1)'(WORDS);
  localparam logic [ADDR_W:0]   NUM_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] CNT_ONE = ADDR_W'(1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W:0]     r_num_words;
  logic [ADDR_W-1:0]   r_word_cnt;
  logic [1:0]          r_byte_idx;
  logic [7:0]          r_csum;
  logic [DATA_W-1:0]   r_word;

  logic w_accept;
  logic w_can_start;
  logic w_num_ok;
  logic w_last_word;

  assign w_accept    = bs.byte_valid & bs.byte_ready;
  assign w_can_start = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR);
  assign w_num_ok    = (num_words != '0) && (num_words <= NUM_MAX);
  assign w_last_word = ({1'b0, r_word_cnt} == (r_num_words - NUM_ONE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          w_state_nxt = w_num_ok ? S_RECV : S_ERR;
        end
      end
      S_RECV: begin
        if (w_accept && (r_byte_idx == 2'd3)) begin
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        w_state_nxt = w_last_word ? S_CHK : S_RECV;
      end
      S_CHK: begin
        if (w_accept) begin
          w_state_nxt = (bs.byte_data == r_csum) ? S_DONE : S_ERR;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Session datapath; the word counter only advances out of WRITE, so it stops at num_words-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_num_words <= '0;
      r_word_cnt  <= '0;
      r_byte_idx  <= '0;
      r_csum      <= '0;
      r_word      <= '0;
    end else begin
      if (w_can_start && start && w_num_ok) begin
        r_num_words <= num_words;
        r_word_cnt  <= '0;
        r_byte_idx  <= '0;
        r_csum      <= '0;
      end
      if ((r_state == S_RECV) && w_accept) begin
        r_word[{r_byte_idx, 3'b000} +: 8] <= bs.byte_data;
        r_byte_idx                        <= r_byte_idx + 2'd1;
        r_csum                            <= r_csum ^ bs.byte_data;
      end
      if ((r_state == S_WRITE) && !w_last_word) begin
        r_word_cnt <= r_word_cnt + CNT_ONE;
      end
    end
  end

  // All status outputs decode straight from the state register.
  assign bs.byte_ready = (r_state == S_RECV) || (r_state == S_CHK);
  assign busy          = (r_state == S_RECV) || (r_state == S_WRITE) || (r_state == S_CHK);
  assign done          = (r_state == S_DONE);
  assign error         = (r_state == S_ERR);
  assign cpu_reset     = (r_state != S_DONE);
  assign imem_we       = (r_state == S_WRITE);
  assign imem_addr     = r_word_cnt;
  assign imem_wdata    = r_word;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte driver tasks feed the stream, a negedge monitor
// checks every instruction-memory write against the expected-write queue.
module tb_imem_loader;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam int WORDS  = 16;
  localparam int EW     = ADDR_W + DATA_W;

  // Status vector order: busy, done, error, cpu_reset, byte_ready, imem_we
  localparam logic [5:0] ST_IDLE = 6'b000100;
  localparam logic [5:0] ST_RECV = 6'b100110;
  localparam logic [5:0] ST_DONE = 6'b010000;
  localparam logic [5:0] ST_ERR  = 6'b001100;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                start = 1'b0;
  logic [ADDR_W:0]     num_words = '0;
  logic                imem_we;
  logic [ADDR_W-1:0]   imem_addr;
  logic [DATA_W-1:0]   imem_wdata;
  logic                cpu_reset;
  logic                busy;
  logic                done;
  logic                error;
  logic [2:0]          dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_exp;
  logic [7:0]    stream [8];
  logic [7:0]    csum16;

  imem_loader_if bs();

  imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_words (num_words),
    .bs        (bs),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, state=%0d", dbg_state);
    $fatal(1, "watchdog expired");
  end

  // Scoreboard monitor: one pop per write cycle; the stream must be stalled while writing.
  always @(negedge clk) begin
    if (!reset && imem_we) begin
      checks++;
      if (bs.byte_ready) begin
        failures++;
        $display("FAIL write_ready: byte_ready=1 during write at addr %0d, expected 0", imem_addr);
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write", imem_addr, imem_wdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== mon_exp) begin
          failures++;
          $display("FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h",
                   imem_addr, imem_wdata, mon_exp[EW-1 -: ADDR_W], mon_exp[DATA_W-1:0]);
        end
      end
    end
  end

  task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic check_status(input string name, input logic [5:0] exp);
    logic [5:0] act;
    act = {busy, done, error, cpu_reset, bs.byte_ready, imem_we};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got busy/done/error/cpu_reset/ready/we=%b, expected %b", name, act, exp);
    end
  endtask

  // Called at posedge+1; samples at the next negedge and resynchronises to posedge+1.
  task automatic status_next(input string name, input logic [5:0] exp);
    @(negedge clk);
    check_status(name, exp);
    @(posedge clk); #1;
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s: got %0d writes still pending, expected 0", name, exp_q.size());
    end
  endtask

  task automatic pulse_start(input logic [ADDR_W:0] n);
    start     = 1'b1;
    num_words = n;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  // Idle for gap cycles, then hold the byte until the edge where ready was high.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit got;
    got = 1'b0;
    bs.byte_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    bs.byte_valid = 1'b1;
    bs.byte_data  = b;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (bs.byte_ready) got = 1'b1;
      @(posedge clk); #1;
    end
    bs.byte_valid = 1'b0;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL byte_accept: byte %h got no ready in 64 cycles, expected acceptance", b);
    end
  endtask

  initial begin
    bs.byte_valid = 1'b0;
    bs.byte_data  = '0;
    stream[0] = 8'h13; stream[1] = 8'h00; stream[2] = 8'h10; stream[3] = 8'h00;
    stream[4] = 8'h93; stream[5] = 8'h80; stream[6] = 8'h20; stream[7] = 8'h00;

    // Reset values
    #3;
    check_status("reset_hold", ST_IDLE);
    checks++;
    if (imem_addr !== '0 || imem_wdata !== '0) begin
      failures++;
      $display("FAIL reset_bus: got addr=%0d data=%h, expected 0/0", imem_addr, imem_wdata);
    end
    #9 reset = 1'b0;
    @(negedge clk);
    check_status("reset_release", ST_IDLE);
    @(posedge clk); #1;

    // Clean 2-word load, no gaps
    push_exp(4'd0, 32'h0010_0013);
    push_exp(4'd1, 32'h0020_8093);
    pulse_start(5'd2);
    status_next("clean_start", ST_RECV);
    for (int i = 0; i < 8; i++) send_byte(stream[i], 0);
    send_byte(8'h30, 0);
    status_next("clean_done", ST_DONE);
    check_drained("clean_drained");

    // Same stream with gaps and ignored start pulses (mid-word and during WRITE)
    push_exp(4'd0, 32'h0010_0013);
    push_exp(4'd1, 32'h0020_8093);
    pulse_start(5'd2);
    status_next("stall_start", ST_RECV);
    for (int i = 0; i < 8; i++) begin
      send_byte(stream[i], i % 4);
      if (i == 1 || i == 3) pulse_start(5'd1);
    end
    send_byte(8'h30, 2);
    status_next("stall_done", ST_DONE);
    check_drained("stall_drained");

    // Bad checksum: words still written, then rejected
    push_exp(4'd0, 32'h0010_0013);
    push_exp(4'd1, 32'h0020_8093);
    pulse_start(5'd2);
    for (int i = 0; i < 8; i++) send_byte(stream[i], 0);
    send_byte(8'h31, 1);
    status_next("badsum_err", ST_ERR);
    check_drained("badsum_drained");

    // Full 16-word load: byte k of word w is 4w+k
    csum16 = '0;
    for (int w = 0; w < 16; w++) begin
      push_exp(4'(w), {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
    end
    pulse_start(5'd16);
    status_next("full_start", ST_RECV);
    for (int w = 0; w < 16; w++) begin
      for (int k = 0; k < 4; k++) begin
        send_byte(8'(4*w+k), (w + k) % 2);
        csum16 = csum16 ^ 8'(4*w+k);
      end
    end
    send_byte(csum16, 0);
    status_next("full_done", ST_DONE);
    check_drained("full_drained");

    // num_words=0 rejected from DONE, no writes
    pulse_start(5'd0);
    status_next("nw0_err", ST_ERR);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check_drained("nw0_drained");

    // Async reset mid-word discards the partial word, then a clean restart
    pulse_start(5'd2);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    reset = 1'b1;
    #2;
    check_status("async_reset", ST_IDLE);
    @(posedge clk); #1;
    reset = 1'b0;
    push_exp(4'd0, 32'h0010_0013);
    pulse_start(5'd1);
    status_next("restart_start", ST_RECV);
    for (int i = 0; i < 4; i++) send_byte(stream[i], 0);
    send_byte(8'h03, 0);
    status_next("restart_done", ST_DONE);
    check_drained("restart_drained");

    // num_words=17 rejected from DONE, no writes
    pulse_start(5'd17);
    status_next("nw17_err", ST_ERR);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check_drained("nw17_drained");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory loader for the mini RISC-V CPU. It receives a program as a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It writes them to consecutive instruction-memory addresses from 0, checks a trailing XOR checksum, and holds the CPU in reset until a load completes cleanly. It sits between the host/bench byte source and the CPU's instruction memory write port, and drives the CPU reset.

## Interface
- ADDR_W, 4, instruction-memory address width; matches the 4-bit PC.
- DATA_W, 32, instruction word width.
- WORDS, 16, instruction-memory depth (2^ADDR_W).
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  single-cycle pulse; begins a load session.
- num_words  in  ADDR_W+1  word count for the session, sampled when start is accepted; valid range 1..WORDS.
- byte_valid  in  1  source has a byte on byte_data.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  instruction-memory write enable.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  DATA_W  write data.
- cpu_reset  out  1  reset to the CPU; high unless a load has finished cleanly.
- busy  out  1  session in progress.
- done  out  1  last session finished with a correct checksum.
- error  out  1  last session was rejected.

## Operation
- The states are IDLE, RECV, WRITE, CHK, DONE and ERR. All outputs are registered or decoded directly from state.
- Reset puts the block in IDLE with byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, error=0 and cpu_reset=1.
- **IDLE, DONE or ERR with start=1:**
  - If num_words is 0 or greater than WORDS, go to ERR.
  - Otherwise latch num_words, clear the word counter, byte index and checksum, and go to RECV.
  - Entering RECV sets cpu_reset=1, done=0 and error=0.
- **start is ignored in RECV, WRITE and CHK.**
- **RECV:**
  - byte_ready=1 in this state.
  - A byte is accepted on an edge where byte_valid and byte_ready are both high.
  - Byte k (k = 0..3) goes into word bits [8k+7:8k].
  - Every accepted byte is XORed into the checksum.
  - After byte 3 is accepted, go to WRITE.
- **WRITE:**
  - Lasts exactly one cycle, with byte_ready=0, imem_we=1, imem_addr set to the word counter and imem_wdata set to the assembled word.
  - Next state is CHK if word counter = num_words-1; otherwise increment the word counter and return to RECV.
- **CHK:**
  - byte_ready=1 in this state.
  - Accept one byte. If it equals the running checksum, go to DONE; otherwise go to ERR.
- **DONE:** busy=0, done=1, cpu_reset=0, byte_ready=0. The block holds here until the next start.
- **ERR:** busy=0, error=1, cpu_reset=1, byte_ready=0. Words already written are not rolled back.
- busy=1 in RECV, WRITE and CHK.
- The word counter never exceeds WORDS-1, so the address does not wrap within a session.

## Timing
- start is sampled at edge T. busy=1 and byte_ready=1 from T+1.
- The 4th byte of a word is accepted at edge N. imem_we is high during cycle N..N+1, and the memory captures the word at edge N+1. byte_ready returns high at N+1.
- Minimum cost is 5 cycles per word, and 4·num_words+num_words+1 cycles per session from the first accepted byte to DONE.
- The checksum byte is accepted at edge C. done or error is high from C+1, and cpu_reset falls at C+1 on success.
- byte_valid gaps stall the session indefinitely with no timeout. A byte presented during WRITE is not consumed and is taken at the next edge.
- An asynchronous reset mid-session immediately forces IDLE outputs, including cpu_reset=1, and discards any partial word.

## Test plan
- **Reset values:** assert reset for 12 ns -> cpu_reset=1, byte_ready=0, busy=done=error=0, imem_we=0.
- **Clean 2-word load:** start with num_words=2, bytes 13 00 10 00 93 80 20 00, checksum 30 -> write addr0=0x00100013 then addr1=0x00208093 (one imem_we cycle each), done=1, cpu_reset=0.
- **Stalls and ignored start:** same stream with byte_valid gaps of 0–3 cycles and a start pulse mid-session -> identical writes, start ignored, byte never consumed during WRITE.
- **Bad checksum:** same stream with checksum 31 -> both words written, error=1, done=0, cpu_reset stays 1.
- **Range checks:**
  - num_words=0 -> ERR next cycle with no writes.
  - num_words=17 -> ERR next cycle with no writes.
  - num_words=16 with correct checksum -> addresses 0..15 written in order, done=1.
- **Reset and restart:** assert reset after byte 2 of word 1, then restart with num_words=1, bytes 13 00 10 00, checksum 03 -> no write from the aborted session, addr0=0x00100013, done=1.
